// File: rtl/dnn_pkg.sv
// Shared definitions for the dense-layer blocks: sequencer states, accumulator sizing
// and Q-format constants.
package dnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        ACT,
        DONE
    } state_t;

    localparam int DEF_FRAC = 8;
    localparam int ONE      = 1 << DEF_FRAC;

    // Headroom of clog2(n+1) bits covers the bias plus n full-scale products.
    function automatic int acc_width(input int width, input int num_input);
        return 2 * width + $clog2(num_input + 1);
    endfunction

    function automatic int q_one(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: load places a Q-format bias at product scale,
// en adds one full-precision product of a and b.
module mac_unit
    import dnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = acc_width(16, 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] load_val,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACCW-1:0]  acc
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    acc_reg;
    logic signed [ACCW-1:0]    acc_next;

    always_comb begin
        prod     = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        acc_next = acc_reg;
        if (load) begin
            // Products carry 2*FRAC fraction bits, so the bias is shifted up by FRAC.
            acc_next = {{(ACCW-WIDTH-FRAC){load_val[WIDTH-1]}}, load_val, {FRAC{1'b0}}};
        end else if (en) begin
            acc_next = acc_reg + {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/hidden_seq.sv
// Sequential hidden layer: one shared MAC walks every perceptron (bias, weights, ReLU).
// Define HIDDEN_SEQ_SAT_EN to saturate activations instead of wrapping them.
module hidden_seq
    import dnn_pkg::*;
#(
    parameter int  NUM_INPUT = 2,
    parameter int  NUM_PCTN  = 3,
    parameter int  WIDTH     = 16,
    parameter int  FRAC      = 8,
    localparam int NCOEF     = NUM_PCTN * (NUM_INPUT + 1),
    localparam int AW        = $clog2(NCOEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NUM_INPUT*WIDTH-1:0]    i_k,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NUM_PCTN*WIDTH-1:0]     o_a,
    input  logic                          wr,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          o_wr_err
);

    localparam int ACCW = acc_width(WIDTH, NUM_INPUT);
    localparam logic [AW-1:0] STRIDE   = AW'(NUM_INPUT + 1);
    localparam logic [AW-1:0] BIAS_OFS = AW'(NUM_INPUT);
    localparam logic [AW-1:0] J_LAST   = AW'(NUM_INPUT - 1);
    localparam logic [AW-1:0] P_LAST   = AW'(NUM_PCTN - 1);

    state_t                  state_reg, state_next;
    logic                    ready_reg;
    logic                    err_reg;
    logic [AW-1:0]           p_reg, j_reg, base_reg;
    logic signed [WIDTH-1:0] k_reg    [NUM_INPUT];
    logic signed [WIDTH-1:0] coef_reg [NCOEF];

    logic                    accept;
    logic                    wr_ok;
    logic [AW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] rd_data;
    logic signed [WIDTH-1:0] k_sel;
    logic signed [WIDTH-1:0] act_word;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  shifted;
    logic                    unused_shifted;

    // ready_reg keeps o_ready low until the first edge after reset releases.
    assign o_ready  = ready_reg && (state_reg == IDLE);
    assign o_valid  = (state_reg == DONE);
    assign o_wr_err = err_reg;
    assign accept   = i_valid && o_ready;
    assign wr_ok    = wr && ({1'b0, wr_addr} < (AW+1)'(NCOEF))
                      && (state_reg == IDLE || state_reg == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BIAS;
            BIAS:    state_next = MAC;
            MAC:     if (j_reg == J_LAST) state_next = ACT;
            ACT:     state_next = (p_reg == P_LAST) ? DONE : BIAS;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            p_reg     <= '0;
            j_reg     <= '0;
            base_reg  <= '0;
            for (int i = 0; i < NUM_INPUT; i++) k_reg[i] <= '0;
        end else begin
            ready_reg <= 1'b1;
            err_reg   <= wr && !wr_ok;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        p_reg    <= '0;
                        base_reg <= '0;
                        for (int i = 0; i < NUM_INPUT; i++) k_reg[i] <= i_k[i*WIDTH +: WIDTH];
                    end
                end
                BIAS: j_reg <= '0;
                MAC:  j_reg <= j_reg + 1'b1;
                ACT: begin
                    p_reg    <= p_reg + 1'b1;
                    base_reg <= base_reg + STRIDE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) coef_reg[i] <= '0;
        end else if (wr_ok) begin
            coef_reg[wr_addr] <= wr_data;
        end
    end

    // One read port serves both the bias (BIAS) and the current weight (MAC).
    assign rd_addr = base_reg + ((state_reg == BIAS) ? BIAS_OFS : j_reg);
    assign rd_data = coef_reg[rd_addr];

    always_comb begin
        k_sel = k_reg[0];
        for (int i = 1; i < NUM_INPUT; i++) begin
            if (j_reg == AW'(i)) k_sel = k_reg[i];
        end
    end

    mac_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg == BIAS),
        .en       (state_reg == MAC),
        .load_val (rd_data),
        .a        (k_sel),
        .b        (rd_data),
        .acc      (acc)
    );

`ifdef HIDDEN_SEQ_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'({1'b0, {(WIDTH-1){1'b1}}});
`endif

    assign shifted        = acc >>> FRAC;
    assign unused_shifted = ^shifted;

    always_comb begin
        act_word = shifted[WIDTH-1:0];
        if (shifted[ACCW-1]) act_word = '0;
`ifdef HIDDEN_SEQ_SAT_EN
        else if (shifted > SAT_MAX) act_word = {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    genvar gi;
    for (gi = 0; gi < NUM_PCTN; gi++) begin : g_act
        logic [WIDTH-1:0] word_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word_reg <= '0;
            end else if (state_reg == ACT && p_reg == AW'(gi)) begin
                word_reg <= act_word;
            end
        end
        assign o_a[gi*WIDTH +: WIDTH] = word_reg;
    end

endmodule

// File: tb/tb_hidden_seq.sv
// Scoreboard bench for hidden_seq at default parameters; honours HIDDEN_SEQ_SAT_EN
// when choosing expected activations.
module tb_hidden_seq;
    import dnn_pkg::*;

    localparam int NI  = 2;
    localparam int NP  = 3;
    localparam int W   = 16;
    localparam int FR  = 8;
    localparam int NC  = NP * (NI + 1);
    localparam int AW  = $clog2(NC);
    localparam int LAT = NP * (NI + 2);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_ready = 1'b0;
    logic            wr = 1'b0;
    logic [NI*W-1:0] i_k = '0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            o_ready, o_valid, o_wr_err;
    logic [NP*W-1:0] o_a;

    int total = 0;
    int bad   = 0;
    logic [NP*W-1:0]   exp_q [$];
    logic signed [W-1:0] mdl [NC];

    always #5 clk = ~clk;

    hidden_seq #(.NUM_INPUT(NI), .NUM_PCTN(NP), .WIDTH(W), .FRAC(FR)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_k      (i_k),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_a      (o_a),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .o_wr_err (o_wr_err)
    );

    function automatic logic [NP*W-1:0] model_out(input logic [NI*W-1:0] k);
        logic [NP*W-1:0]   r = '0;
        longint            acc;
        longint            s;
        logic signed [W-1:0] kw;
        for (int p = 0; p < NP; p++) begin
            acc = longint'(mdl[p*(NI+1)+NI]) * (longint'(1) << FR);
            for (int j = 0; j < NI; j++) begin
                kw  = k[j*W +: W];
                acc = acc + longint'(kw) * longint'(mdl[p*(NI+1)+j]);
            end
            s = acc >>> FR;
            if (s < 0) s = 0;
`ifdef HIDDEN_SEQ_SAT_EN
            if (s > 32767) s = 32767;
`endif
            r[p*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    // Called #1 after a rising edge with the FSM in IDLE or DONE.
    task automatic wr_coef(input int addr, input logic [W-1:0] data, input bit ok);
        wr = 1'b1; wr_addr = AW'(addr); wr_data = data;
        @(posedge clk); #1;
        wr = 1'b0;
        total++;
        if (o_wr_err !== (ok ? 1'b0 : 1'b1)) begin
            bad++;
            $display("FAIL wr_err addr=%0d got=%b want=%b", addr, o_wr_err, !ok);
        end
        if (ok) mdl[addr] = data;
    endtask

    task automatic set_all(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] b);
        for (int p = 0; p < NP; p++) begin
            wr_coef(p*(NI+1),     w0, 1'b1);
            wr_coef(p*(NI+1) + 1, w1, 1'b1);
            wr_coef(p*(NI+1) + 2, b,  1'b1);
        end
    endtask

    task automatic run_vec(input logic [NI*W-1:0] k, input bit mid_wr, input int hold);
        logic [NP*W-1:0] e;
        logic [NP*W-1:0] held;
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_timeout got=%b want=1", o_ready); end
        i_valid = 1'b1; i_k = k;
        @(posedge clk); #1;
        i_valid = 1'b0;
        n = 0;
        if (mid_wr) begin
            @(posedge clk); #1; n++;
            wr = 1'b1; wr_addr = '0; wr_data = 16'h1234;
            @(posedge clk); #1; n++;
            wr = 1'b0;
            total++;
            if (o_wr_err !== 1'b1) begin bad++; $display("FAIL busy_wr_err got=%b want=1", o_wr_err); end
            @(posedge clk); #1; n++;
            total++;
            if (o_wr_err !== 1'b0) begin bad++; $display("FAIL wr_err_pulse got=%b want=0", o_wr_err); end
        end
        while (o_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++;
        if (n != LAT) begin bad++; $display("FAIL latency got=%0d want=%0d", n, LAT); end
        total++;
        if (exp_q.size() == 0) begin
            bad++; $display("FAIL scoreboard_empty got=%h want=<expected entry>", o_a);
        end else begin
            e = exp_q.pop_front();
            if (o_a !== e) begin bad++; $display("FAIL o_a got=%h want=%h", o_a, e); end
        end
        $display("vec k=%h o_a=%h cycles=%0d", k, o_a, n);
        held = o_a;
        for (int c = 0; c < hold; c++) begin
            if (c == 0) begin wr = 1'b1; wr_addr = '0; wr_data = 16'h0000; end
            @(posedge clk); #1;
            if (c == 0) begin
                wr = 1'b0; mdl[0] = 16'h0000;
                total++;
                if (o_wr_err !== 1'b0) begin bad++; $display("FAIL done_wr_err got=%b want=0", o_wr_err); end
            end
            total++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_a !== held) begin
                bad++;
                $display("FAIL hold c=%0d got v=%b r=%b a=%h want v=1 r=0 a=%h", c, o_valid, o_ready, o_a, held);
            end
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL release got v=%b r=%b want v=0 r=1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NC; i++) mdl[i] = '0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_a !== '0 || o_wr_err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got r=%b v=%b a=%h e=%b want all 0", o_ready, o_valid, o_a, o_wr_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b want=0", o_ready); end
        @(posedge clk); #1;
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b want=1", o_ready); end
    endtask

    task automatic test_basic();
        set_all(16'h0100, 16'h0200, 16'h0080);
        exp_q.push_back({3{16'h0380}});
        run_vec({W'(ONE), W'(ONE)}, 1'b0, 0);
    endtask

    task automatic test_relu();
        set_all(16'h0000, 16'h0000, 16'hFF00);
        exp_q.push_back('0);
        run_vec({16'h1234, 16'h0567}, 1'b0, 0);
    endtask

    task automatic test_sat();
        set_all(16'h7F00, 16'h7F00, 16'h0000);
`ifdef HIDDEN_SEQ_SAT_EN
        exp_q.push_back({3{16'h7FFF}});
`else
        exp_q.push_back({3{16'h0200}});
`endif
        run_vec({16'h7F00, 16'h7F00}, 1'b0, 0);
    endtask

    task automatic test_model();
        logic [NI*W-1:0] k;
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < NC; a++) wr_coef(a, W'($urandom_range(0, 16'hFFFF)), 1'b1);
            k = {W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF))};
            exp_q.push_back(model_out(k));
            run_vec(k, 1'b0, 0);
        end
    endtask

    task automatic test_hold();
        set_all(16'h0100, 16'h0200, 16'h0080);
        exp_q.push_back({3{16'h0380}});
        run_vec({16'h0100, 16'h0100}, 1'b0, 5);
    endtask

    task automatic test_wr_err();
        set_all(16'h0100, 16'h0200, 16'h0080);
        wr_coef(9, 16'h5555, 1'b0);
        exp_q.push_back({3{16'h0380}});
        run_vec({16'h0100, 16'h0100}, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        set_all(16'h0100, 16'h0200, 16'h0080);
        exp_q.push_back({3{16'h0380}});
        run_vec({16'h0100, 16'h0100}, 1'b0, 0);
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        i_valid = 1'b1; i_k = {16'h0100, 16'h0100};
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_a !== '0 || o_wr_err !== 1'b0) begin
            bad++; $display("FAIL mid_reset got v=%b r=%b a=%h e=%b want all 0", o_valid, o_ready, o_a, o_wr_err);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid c=%0d got=%b want=0", c, o_valid); end
        end
        rst = 1'b1;
        for (int i = 0; i < NC; i++) mdl[i] = '0;
        @(posedge clk); #1;
        exp_q.push_back('0);
        run_vec({16'h0100, 16'h0100}, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_sat();
        test_model();
        test_hold();
        test_wr_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hidden_seq.md
HIDDEN_SEQ -- requirements
Module: hidden_seq

Interface
REQ-001 The block SHALL have parameter NUM_INPUT, default 2, meaning inputs per perceptron.
REQ-002 The block SHALL have parameter NUM_PCTN, default 3, meaning perceptrons in the layer.
REQ-003 The block SHALL have parameter WIDTH, default 16, meaning signed fixed-point word width.
REQ-004 The block SHALL have parameter FRAC, default 8, meaning fractional bits (Q(WIDTH-FRAC).FRAC).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- i_valid  in  1  input vector valid.
- o_ready  out  1  block can accept an input vector.
- i_k  in  NUM_INPUT*WIDTH  input vector; word j at bits [j*WIDTH +: WIDTH].
- o_valid  out  1  output vector valid.
- i_ready  in  1  downstream accepts the output vector.
- o_a  out  NUM_PCTN*WIDTH  activations; perceptron p at bits [p*WIDTH +: WIDTH].
- wr  in  1  coefficient write strobe.
- wr_addr  in  AW=$clog2(NUM_PCTN*(NUM_INPUT+1))  coefficient address: p*(NUM_INPUT+1)+j (weight j), p*(NUM_INPUT+1)+NUM_INPUT (bias).
- wr_data  in  WIDTH  coefficient value.
- o_wr_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-007 The FSM SHALL have states IDLE, BIAS, MAC, ACT and DONE.
REQ-008 In IDLE, o_ready SHALL be 1; i_valid&&o_ready SHALL latch i_k and go to BIAS with p=0.
REQ-009 BIAS SHALL load acc with the bias of p, sign-extended and aligned to the product scale; j=0; next state MAC.
REQ-010 Each MAC cycle SHALL do acc += k[j]*w[p][j] (full 2*WIDTH signed product, acc width 2*WIDTH+$clog2(NUM_INPUT+1)); after j=NUM_INPUT-1, next state ACT.
REQ-011 ACT SHALL compute r = acc>>>FRAC, apply ReLU (negative becomes 0), convert to WIDTH and write o_a word p; if p<NUM_PCTN-1 then p++ and go to BIAS, else go to DONE.
REQ-012 Latency SHALL be exactly NUM_PCTN*(NUM_INPUT+2) cycles from the accept edge to o_valid=1.
REQ-013 In DONE, o_valid SHALL be 1 and o_a held stable; i_ready=1 SHALL return the FSM to IDLE on the next edge, and o_ready SHALL NOT be combinationally tied to i_ready.
REQ-014 o_a SHALL change only in ACT; partial results are visible but qualified only by o_valid.
REQ-015 A write SHALL take effect in IDLE or DONE only; in BIAS/MAC/ACT it SHALL be dropped and o_wr_err pulsed on the next cycle.
REQ-016 A write with wr_addr >= NUM_PCTN*(NUM_INPUT+1) SHALL be dropped and o_wr_err pulsed.
REQ-017 A write in DONE SHALL NOT alter the held o_a.

Reset
REQ-018 While rst=0, the FSM SHALL be in IDLE, o_valid=0, o_ready=0, o_a=0, o_wr_err=0, acc=0, and all coefficients 0.
REQ-019 o_ready SHALL rise on the first clock edge after rst deasserts; reset mid-computation SHALL abort the computation with no o_valid pulse.

Configuration
REQ-020 With HIDDEN_SEQ_SAT_EN defined, the ACT conversion SHALL saturate at 2^(WIDTH-1)-1; without it, it SHALL keep the low WIDTH bits (wrap).

Structure
REQ-021 The shared package dnn_pkg SHALL hold the FSM state enum, the accumulator-width function, and the Q-format constants (ONE = 1<<FRAC).
REQ-022 Multiply-accumulate SHALL be the sub-module mac_unit (clear/load, accumulate enable, signed product); coefficient storage and the FSM stay in hidden_seq.

Verification (NUM_INPUT=2, NUM_PCTN=3, WIDTH=16, FRAC=8)
REQ-023 Write w[p][0]=0x0100, w[p][1]=0x0200 and bias 0x0080 for all p, send k={0x0100,0x0100} -> o_valid after 12 cycles with every o_a word 0x0380.
REQ-024 Bias 0xFF00 and all weights 0 -> every o_a word 0x0000 (ReLU).
REQ-025 w=0x7F00 and k=0x7F00 for all inputs -> 0x7FFF with HIDDEN_SEQ_SAT_EN; the wrapped low 16 bits without it.
REQ-026 Hold i_ready=0 for 5 cycles in DONE -> o_valid and o_a stable, o_ready=0; then i_ready=1 -> IDLE next cycle.
REQ-027 Write during MAC and a write to wr_addr=9 -> o_wr_err pulses, coefficients unchanged, result matches REQ-023.
REQ-028 Drive rst=0 in the middle of MAC -> all outputs 0 immediately, no o_valid; a new vector after reset computes with zeroed coefficients.
